poly_sweep: RTL and testbench

- Sequencer directly upstream of the polynomial solver.
- On `go`, latches coefficients a, b, c and a signed x range, then issues one solver run per x point (x_first, x_first+x_step, … ≤ x_last).
- Captures each solver result and streams (x, y) pairs out on a valid/ready port through a one-entry output buffer.
- Tracks point count, min/max y and a timeout error; lets a single solver evaluate a whole table without host micromanagement.

---
 rtl/poly_sweep.sv | 218 +++++++++++++++++++++
 tb/tb_poly_sweep.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_sweep.sv
// Sweep sequencer for the polynomial solver: steps x over a signed range,
// runs the solver once per point and streams (x, y) pairs with statistics.
module poly_sweep #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [7:0]       x_first,
  input  logic [7:0]       x_last,
  input  logic [3:0]       x_step,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [15:0]      c,
  output logic             sv_start,
  output logic [7:0]       sv_x,
  output logic [15:0]      sv_a,
  output logic [15:0]      sv_b,
  output logic [15:0]      sv_c,
  input  logic             sv_ready,
  input  logic             sv_valid,
  input  logic [15:0]      sv_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_x,
  output logic [15:0]      out_y,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      y_min,
  output logic [15:0]      y_max
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cur_x_q, cur_x_d;
  logic [7:0]       x_last_q, x_last_d;
  logic [3:0]       step_q, step_d;
  logic [15:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic             sv_start_q, sv_start_d;
  logic [7:0]       sv_x_q, sv_x_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_x_q, out_x_d;
  logic [15:0]      out_y_q, out_y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      y_min_q, y_min_d;
  logic [15:0]      y_max_q, y_max_d;

  logic signed [8:0] next_x;
  logic signed [8:0] last9;
  logic              stop;

  // Next x is formed one bit wider so a step past +127 cannot wrap negative.
  assign next_x = {cur_x_q[7], cur_x_q} + {5'd0, step_q};
  assign last9  = {x_last_q[7], x_last_q};
  assign stop   = (next_x > last9) || (next_x > 9'sd127);

  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    x_last_d    = x_last_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    sv_start_d  = 1'b0;
    sv_x_d      = sv_x_q;
    timer_d     = timer_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    count_d     = count_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_x_d  = x_first;
          x_last_d = x_last;
          step_d   = (x_step == 4'd0) ? 4'd1 : x_step;
          a_d      = a;
          b_d      = b;
          c_d      = c;
          count_d  = '0;
          error_d  = 1'b0;
          y_min_d  = 16'h7FFF;
          y_max_d  = 16'h8000;
          busy_d   = 1'b1;
          if ($signed(x_first) > $signed(x_last))
            state_d = S_FINISH;
          else
            state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sv_ready) begin
          sv_start_d = 1'b1;
          sv_x_d     = cur_x_q;
          timer_d    = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // The start-pulse cycle itself never counts as a result.
        if (!sv_start_q && sv_valid) begin
          out_valid_d = 1'b1;
          out_x_d     = cur_x_q;
          out_y_d     = sv_y;
          state_d     = S_EMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_q + CNT_W'(1);
          if ($signed(out_y_q) < $signed(y_min_q))
            y_min_d = out_y_q;
          if ($signed(out_y_q) > $signed(y_max_q))
            y_max_d = out_y_q;
          if (stop) begin
            state_d = S_FINISH;
          end else begin
            cur_x_d = next_x[7:0];
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_x_q     <= '0;
      x_last_q    <= '0;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sv_start_q  <= 1'b0;
      sv_x_q      <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      x_last_q    <= x_last_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sv_start_q  <= sv_start_d;
      sv_x_q      <= sv_x_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      count_q     <= count_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
    end
  end

  assign sv_start  = sv_start_q;
  assign sv_x      = sv_x_q;
  assign sv_a      = a_q;
  assign sv_b      = b_q;
  assign sv_c      = c_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign count     = count_q;
  assign y_min     = y_min_q;
  assign y_max     = y_max_q;

endmodule

// File: tb/tb_poly_sweep.sv
// Directed bench for poly_sweep with a behavioural solver model;
// DUT outputs are sampled on the falling clock edge.
module tb_poly_sweep;

  logic        clock;
  logic        reset;
  logic        go;
  logic [7:0]  x_first, x_last;
  logic [3:0]  x_step;
  logic [15:0] a, b, c;
  logic        sv_start;
  logic [7:0]  sv_x;
  logic [15:0] sv_a, sv_b, sv_c;
  logic        sv_ready;
  logic        sv_valid = 1'b0;
  logic [15:0] sv_y = 16'h0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_x;
  logic [15:0] out_y;
  logic        busy, done, error;
  logic [8:0]  count;
  logic [15:0] y_min, y_max;

  int n_chk  = 0;
  int n_pass = 0;

  poly_sweep #(.TIMEOUT(64), .CNT_W(9)) dut (
    .clock(clock), .reset(reset), .go(go),
    .x_first(x_first), .x_last(x_last), .x_step(x_step),
    .a(a), .b(b), .c(c),
    .sv_start(sv_start), .sv_x(sv_x),
    .sv_a(sv_a), .sv_b(sv_b), .sv_c(sv_c),
    .sv_ready(sv_ready), .sv_valid(sv_valid), .sv_y(sv_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .error(error), .count(count),
    .y_min(y_min), .y_max(y_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Solver model: one job at a time, result after sol_lat+1 cycles.
  logic sol_en = 1'b1;
  int   sol_lat = 0;
  logic pend = 1'b0;
  int   lat_cnt = 0;
  logic [15:0] pend_y = 16'h0;

  function automatic logic [15:0] poly(input logic [15:0] pa, pb, pc,
                                       input logic [7:0] px);
    int x;
    x = int'($signed(px));
    return 16'(int'($signed(pa)) * x * x + int'($signed(pb)) * x
               + int'($signed(pc)));
  endfunction

  assign sv_ready = !pend;

  always @(posedge clock) begin
    sv_valid <= 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        sv_valid <= 1'b1;
        sv_y     <= pend_y;
        pend     <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (sv_start && sol_en) begin
      pend    <= 1'b1;
      lat_cnt <= sol_lat;
      pend_y  <= poly(sv_a, sv_b, sv_c, sv_x);
    end
  end

  int done_cnt  = 0;
  int start_cnt = 0;
  always @(negedge clock) begin
    if (done) done_cnt = done_cnt + 1;
    if (sv_start) start_cnt = start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start(input logic [7:0] xf, xl, input logic [3:0] st,
                       input logic [15:0] ca, cb, cc);
    x_first = xf;
    x_last  = xl;
    x_step  = st;
    a       = ca;
    b       = cb;
    c       = cc;
    go      = 1'b1;
    @(negedge clock);
    go      = 1'b0;
  endtask

  task automatic wait_pair(input string tag, input logic [7:0] ex,
                           input logic [15:0] ey);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_x"}, 32'(out_x), 32'(ex));
    check({tag, "_y"}, 32'(out_y), 32'(ey));
  endtask

  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 32'(found), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  int   base_done;
  int   base_start;
  logic found;
  logic seen_ov, seen_st, seen_sv;

  initial begin
    reset = 1'b1;
    go = 1'b0;
    x_first = 8'h0; x_last = 8'h0; x_step = 4'h0;
    a = 16'h0; b = 16'h0; c = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ctl", {28'h0, busy, done, error, out_valid}, 32'h0);
    check("rst_sv", {7'h0, sv_start, sv_x, sv_a}, 32'h0);
    check("rst_out", {8'h0, out_x, out_y}, 32'h0);
    check("rst_cnt", 32'(count), 32'h0);
    check("rst_mm", {y_min, y_max}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // x^2 over -2..2
    base_done = done_cnt;
    start(8'hFE, 8'h02, 4'd1, 16'd1, 16'd0, 16'd0);
    check("t1_nostart0", 32'(sv_start), 32'd0);
    @(negedge clock);
    check("t1_lat", 32'(sv_start), 32'd1);
    check("t1_svx", 32'(sv_x), 32'hFE);
    wait_pair("t1_p0", 8'hFE, 16'd4);
    wait_pair("t1_p1", 8'hFF, 16'd1);
    wait_pair("t1_p2", 8'h00, 16'd0);
    wait_pair("t1_p3", 8'h01, 16'd1);
    wait_pair("t1_p4", 8'h02, 16'd4);
    wait_done("t1");
    check("t1_count", 32'(count), 32'd5);
    check("t1_ymin", 32'(y_min), 32'h0000);
    check("t1_ymax", 32'(y_max), 32'h0004);
    check("t1_err", 32'(error), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_ndone", 32'(done_cnt - base_done), 32'd1);

    // 120..127 step 5, must not wrap
    base_start = start_cnt;
    start(8'd120, 8'd127, 4'd5, 16'd1, 16'd0, 16'd0);
    wait_pair("t2_p0", 8'd120, 16'h3840);
    wait_pair("t2_p1", 8'd125, 16'h3D09);
    wait_done("t2");
    check("t2_count", 32'(count), 32'd2);
    check("t2_nstart", 32'(start_cnt - base_start), 32'd2);
    check("t2_ymin", 32'(y_min), 32'h3840);
    check("t2_ymax", 32'(y_max), 32'h3D09);

    // Empty range
    base_start = start_cnt;
    start(8'd3, 8'hFD, 4'd1, 16'd1, 16'd0, 16'd0);
    check("t3_done_early", 32'(done), 32'd0);
    @(negedge clock);
    check("t3_done", 32'(done), 32'd1);
    repeat (3) @(negedge clock);
    check("t3_count", 32'(count), 32'd0);
    check("t3_ymin", 32'(y_min), 32'h7FFF);
    check("t3_ymax", 32'(y_max), 32'h8000);
    check("t3_nstart", 32'(start_cnt - base_start), 32'd0);

    // Output stall, step 0 acts as 1, y = x^2+2x+3
    out_ready = 1'b0;
    base_start = start_cnt;
    start(8'd0, 8'd1, 4'd0, 16'd1, 16'd2, 16'd3);
    wait_pair("t4_p0", 8'h00, 16'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t4_stall", {7'h0, out_valid, out_x, out_y},
            {7'h0, 1'b1, 8'h00, 16'h0003});
    end
    check("t4_onestart", 32'(start_cnt - base_start), 32'd1);
    out_ready = 1'b1;
    @(negedge clock);
    check("t4_drop", 32'(out_valid), 32'd0);
    wait_pair("t4_p1", 8'h01, 16'd6);
    wait_done("t4");
    check("t4_count", 32'(count), 32'd2);
    check("t4_ymin", 32'(y_min), 32'h0003);
    check("t4_ymax", 32'(y_max), 32'h0006);

    // Solver never answers
    sol_en = 1'b0;
    start(8'd5, 8'd6, 4'd1, 16'd1, 16'd0, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (sv_start) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_start", 32'(found), 32'd1);
    repeat (63) @(negedge clock);
    check("t5_err_early", 32'(error), 32'd0);
    @(negedge clock);
    check("t5_err", 32'(error), 32'd1);
    @(negedge clock);
    check("t5_done", {30'h0, done, busy}, {30'h0, 1'b1, 1'b0});
    repeat (2) @(negedge clock);
    sol_en = 1'b1;
    start(8'd0, 8'd0, 4'd1, 16'd1, 16'd0, 16'd0);
    check("t5_errclr", 32'(error), 32'd0);
    wait_pair("t5_p0", 8'h00, 16'd0);
    wait_done("t5");

    // Reset during WAIT of the third point
    sol_lat = 6;
    start(8'd0, 8'd5, 4'd1, 16'd1, 16'd0, 16'd0);
    wait_pair("t6_p0", 8'h00, 16'd0);
    wait_pair("t6_p1", 8'h01, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sv_start && sv_x == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_third", 32'(found), 32'd1);
    repeat (2) @(negedge clock);
    check("t6_pre_cnt", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_ctl", {28'h0, busy, done, error, out_valid}, 32'h0);
    check("t6_rst_cnt", 32'(count), 32'd0);
    check("t6_rst_sv", {7'h0, sv_start, sv_x, sv_a}, 32'h0);
    check("t6_rst_mm", {y_min, y_max}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    seen_ov = 1'b0;
    seen_st = 1'b0;
    seen_sv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) seen_ov = 1'b1;
      if (sv_start) seen_st = 1'b1;
      if (sv_valid) seen_sv = 1'b1;
    end
    check("t6_late_valid", 32'(seen_sv), 32'd1);
    check("t6_no_out", 32'(seen_ov), 32'd0);
    check("t6_no_start", 32'(seen_st), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
